// File: rtl/ac_run_level_if.sv
// ac_run_level_if -- coefficient-in / run-level-out bundle for ac_run_level.
//
// Parameter:
//   RUN_W        width of rl_run (must match the RUN_W of the attached block)
// Signals:
//   coef_valid   producer offers coef / coef_last
//   coef         signed quantized coefficient, scan order
//   coef_last    final coefficient of the slice
//   coef_ready   block accepts coef this cycle
//   rl_valid     run/level pair presented
//   out_ready    consumer takes the pair
//   rl_run       zeros preceding the level
//   rl_abs_level magnitude of the nonzero coefficient
//   rl_sign      1 = negative coefficient
//   run_cb       run codebook index
//   lev_cb       level codebook index
//   slice_done   one-cycle pulse ending the slice
// Modports: master = producer/consumer side, slave = ac_run_level.
interface ac_run_level_if #(
  parameter int RUN_W = 16
);
  logic               coef_valid;
  logic signed [31:0] coef;
  logic               coef_last;
  logic               coef_ready;
  logic               rl_valid;
  logic               out_ready;
  logic [RUN_W-1:0]   rl_run;
  logic [31:0]        rl_abs_level;
  logic               rl_sign;
  logic [3:0]         run_cb;
  logic [3:0]         lev_cb;
  logic               slice_done;

  modport master (
    output coef_valid, coef, coef_last, out_ready,
    input  coef_ready, rl_valid, rl_run, rl_abs_level, rl_sign,
           run_cb, lev_cb, slice_done
  );

  modport slave (
    input  coef_valid, coef, coef_last, out_ready,
    output coef_ready, rl_valid, rl_run, rl_abs_level, rl_sign,
           run_cb, lev_cb, slice_done
  );
endinterface

// File: rtl/ac_run_level.sv
// ac_run_level -- converts a scan-ordered stream of quantized AC coefficients
// into (run, |level|, sign) pairs with a one-deep registered output.
//
// Ports:
//   clock    sole clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      ac_run_level_if.slave (coefficient input, pair output,
//            codebook indices, slice_done)
// Parameter:
//   RUN_W    width of the zero-run counter and rl_run (saturating)
// Configuration macro:
//   AC_RL_CB_IDX_EN  when defined, tracks the previous run/level and drives
//                    run_cb/lev_cb; otherwise both indices are tied to 0.
module ac_run_level #(
  parameter int RUN_W = 16
) (
  input logic          clock,
  input logic          reset_n,
  ac_run_level_if.slave bus
);

  function automatic logic [RUN_W-1:0] sat_inc(input logic [RUN_W-1:0] r);
    if (&r) return r;
    return r + RUN_W'(1);
  endfunction

  // The most negative coefficient has no positive twin; clip its magnitude.
  function automatic logic [31:0] abs_sat(input logic signed [31:0] v);
    if (v == 32'sh8000_0000) return 32'h7FFF_FFFF;
    if (v < 0) return $unsigned(-v);
    return $unsigned(v);
  endfunction

  logic             accept;
  logic             ready;
  logic [RUN_W-1:0] run_q, run_d;
  logic             vld_q, vld_d;
  logic [RUN_W-1:0] rl_run_q, rl_run_d;
  logic [31:0]      abs_q, abs_d;
  logic             sign_q, sign_d;
  logic             done_q, done_d;

  // The output register frees up in the same cycle it is drained.
  assign ready  = !vld_q || bus.out_ready;
  assign accept = bus.coef_valid && ready;

  always_comb begin
    vld_d    = vld_q;
    run_d    = run_q;
    rl_run_d = rl_run_q;
    abs_d    = abs_q;
    sign_d   = sign_q;
    done_d   = accept && bus.coef_last;
    if (vld_q && bus.out_ready) vld_d = 1'b0;
    if (accept) begin
      if (bus.coef == '0) begin
        run_d = sat_inc(run_q);
      end else begin
        vld_d    = 1'b1;
        rl_run_d = run_q;
        abs_d    = abs_sat(bus.coef);
        sign_d   = bus.coef[31];
        run_d    = '0;
      end
      // Trailing zeros of the slice are dropped here, never emitted.
      if (bus.coef_last) run_d = '0;
    end
  end

  // ---- stage boundary: accepted coefficient -> registered pair ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      run_q    <= '0;
      vld_q    <= 1'b0;
      rl_run_q <= '0;
      abs_q    <= '0;
      sign_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      run_q    <= run_d;
      vld_q    <= vld_d;
      rl_run_q <= rl_run_d;
      abs_q    <= abs_d;
      sign_q   <= sign_d;
      done_q   <= done_d;
    end
  end

  assign bus.coef_ready   = ready;
  assign bus.rl_valid     = vld_q;
  assign bus.rl_run       = rl_run_q;
  assign bus.rl_abs_level = abs_q;
  assign bus.rl_sign      = sign_q;
  assign bus.slice_done   = done_q;

`ifdef AC_RL_CB_IDX_EN
  function automatic logic [3:0] clamp_cb(input logic [31:0] v, input logic [3:0] lim);
    return (v > {28'd0, lim}) ? lim : v[3:0];
  endfunction

  logic       load;
  logic [3:0] prev_run_q, prev_run_d;
  logic [3:0] prev_lev_q, prev_lev_d;
  logic [3:0] rcb_q, rcb_d;
  logic [3:0] lcb_q, lcb_d;

  // prev_* are stored already clamped (<=15 / <=9), so the index of the
  // new pair is simply the stored value from before this pair's update.
  always_comb begin
    load       = accept && (bus.coef != '0);
    prev_run_d = prev_run_q;
    prev_lev_d = prev_lev_q;
    rcb_d      = rcb_q;
    lcb_d      = lcb_q;
    if (load) begin
      rcb_d      = prev_run_q;
      lcb_d      = prev_lev_q;
      prev_run_d = clamp_cb(32'(run_q), 4'd15);
      prev_lev_d = clamp_cb(abs_sat(bus.coef), 4'd9);
    end
    if (accept && bus.coef_last) begin
      prev_run_d = 4'd4;
      prev_lev_d = 4'd2;
    end
  end

  // ---- stage boundary: codebook context registers ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_run_q <= 4'd4;
      prev_lev_q <= 4'd2;
      rcb_q      <= '0;
      lcb_q      <= '0;
    end else begin
      prev_run_q <= prev_run_d;
      prev_lev_q <= prev_lev_d;
      rcb_q      <= rcb_d;
      lcb_q      <= lcb_d;
    end
  end

  assign bus.run_cb = rcb_q;
  assign bus.lev_cb = lcb_q;
`else
  assign bus.run_cb = 4'd0;
  assign bus.lev_cb = 4'd0;
`endif

endmodule
